// File: rtl/zeroriscy_compressed_encoder.sv
// rtl/zeroriscy_compressed_encoder.sv - RV32I to RVC compressor with little-endian parcel packer
// Define ZERORISCY_CENC_STACK_EN to also compress the SP-relative forms (C.LWSP/C.SWSP/C.ADDI16SP/C.ADDI4SPN).
module zeroriscy_compressed_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic             flush_i,
  output logic [31:0]      word_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic             idle_o,
  output logic [CNT_W-1:0] cmp_count_o
);

`ifdef ZERORISCY_CENC_STACK_EN
  localparam logic STACK_EN = 1'b1;
`else
  localparam logic STACK_EN = 1'b0;
`endif

  localparam logic S_EMPTY = 1'b0;
  localparam logic S_HALF  = 1'b1;

  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm_i, imm_s;
  logic [20:0] jimm;
  logic [12:0] bimm;
  logic        rd_p, rs1_p, rs2_p, fits6;
  logic        in32, c_ok, is16;
  logic [15:0] c_par, p16;

  assign opc   = instr_i[6:0];
  assign rd    = instr_i[11:7];
  assign f3    = instr_i[14:12];
  assign rs1   = instr_i[19:15];
  assign rs2   = instr_i[24:20];
  assign f7    = instr_i[31:25];
  assign imm_i = instr_i[31:20];
  assign imm_s = {instr_i[31:25], instr_i[11:7]};
  assign jimm  = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign bimm  = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign rd_p  = (rd[4:3] == 2'b01);
  assign rs1_p = (rs1[4:3] == 2'b01);
  assign rs2_p = (rs2[4:3] == 2'b01);
  assign fits6 = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);
  assign in32  = (instr_i[1:0] == 2'b11);

  always_comb begin
    c_ok  = 1'b0;
    c_par = 16'h0000;
    case (opc)
      7'b0010011: begin
        case (f3)
          3'b000: begin
            if (STACK_EN && rd == 5'd2 && rs1 == 5'd2 && imm_i[3:0] == 4'h0 && imm_i != 12'h000 &&
                (imm_i[11:9] == 3'b000 || imm_i[11:9] == 3'b111)) begin
              c_ok  = 1'b1;
              c_par = {3'b011, imm_i[9], 5'd2, imm_i[4], imm_i[6], imm_i[8:7], imm_i[5], 2'b01};
            end else if (STACK_EN && rs1 == 5'd2 && rd_p && imm_i[11:10] == 2'b00 &&
                         imm_i[1:0] == 2'b00 && imm_i != 12'h000) begin
              c_ok  = 1'b1;
              c_par = {3'b000, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], 2'b00};
            end else if (rd != 5'd0 && rs1 == rd && imm_i != 12'h000 && fits6) begin
              c_ok  = 1'b1;
              c_par = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
            end else if (rd != 5'd0 && rs1 == 5'd0 && fits6) begin
              c_ok  = 1'b1;
              c_par = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
            end
          end
          3'b001: begin
            if (f7 == 7'h00 && rd != 5'd0 && rs1 == rd && rs2 != 5'd0) begin
              c_ok  = 1'b1;
              c_par = {3'b000, 1'b0, rd, rs2, 2'b10};
            end
          end
          3'b101: begin
            if ((f7 == 7'h00 || f7 == 7'h20) && rd_p && rs1 == rd && rs2 != 5'd0) begin
              c_ok  = 1'b1;
              c_par = {3'b100, 1'b0, 1'b0, f7[5], rd[2:0], rs2, 2'b01};
            end
          end
          3'b111: begin
            if (rd_p && rs1 == rd && fits6) begin
              c_ok  = 1'b1;
              c_par = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
            end
          end
          default: ;
        endcase
      end
      7'b0110011: begin
        if (f3 == 3'b000 && f7 == 7'h00 && rd != 5'd0 && rs2 != 5'd0 && rs1 == 5'd0) begin
          c_ok  = 1'b1;
          c_par = {4'b1000, rd, rs2, 2'b10};
        end else if (f3 == 3'b000 && f7 == 7'h00 && rd != 5'd0 && rs2 != 5'd0 && rs1 == rd) begin
          c_ok  = 1'b1;
          c_par = {4'b1001, rd, rs2, 2'b10};
        end else if (rd_p && rs2_p && rs1 == rd) begin
          if (f7 == 7'h20 && f3 == 3'b000) begin
            c_ok  = 1'b1;
            c_par = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
          end else if (f7 == 7'h00 && (f3 == 3'b100 || f3 == 3'b110 || f3 == 3'b111)) begin
            c_ok  = 1'b1;
            c_par = {6'b100011, rd[2:0], (f3 == 3'b100) ? 2'b01 : {1'b1, f3[0]}, rs2[2:0], 2'b01};
          end
        end
      end
      7'b0110111: begin
        // C.LUI needs the 20-bit immediate to be a sign-extended, non-zero 6-bit value.
        if (rd != 5'd0 && rd != 5'd2 && instr_i[31:12] != 20'h0 &&
            ((&instr_i[31:17]) || !(|instr_i[31:17]))) begin
          c_ok  = 1'b1;
          c_par = {3'b011, instr_i[17], rd, instr_i[16:12], 2'b01};
        end
      end
      7'b0000011: begin
        if (f3 == 3'b010 && rd_p && rs1_p && imm_i[11:7] == 5'h00 && imm_i[1:0] == 2'b00) begin
          c_ok  = 1'b1;
          c_par = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end else if (STACK_EN && f3 == 3'b010 && rs1 == 5'd2 && rd != 5'd0 &&
                     imm_i[11:8] == 4'h0 && imm_i[1:0] == 2'b00) begin
          c_ok  = 1'b1;
          c_par = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
        end
      end
      7'b0100011: begin
        if (f3 == 3'b010 && rs2_p && rs1_p && imm_s[11:7] == 5'h00 && imm_s[1:0] == 2'b00) begin
          c_ok  = 1'b1;
          c_par = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        end else if (STACK_EN && f3 == 3'b010 && rs1 == 5'd2 &&
                     imm_s[11:8] == 4'h0 && imm_s[1:0] == 2'b00) begin
          c_ok  = 1'b1;
          c_par = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
        end
      end
      7'b1101111: begin
        if (rd[4:1] == 4'h0 && ((&jimm[20:11]) || !(|jimm[20:11]))) begin
          c_ok  = 1'b1;
          c_par = {rd[0] ? 3'b001 : 3'b101, jimm[11], jimm[4], jimm[9:8], jimm[10], jimm[6],
                   jimm[7], jimm[3:1], jimm[5], 2'b01};
        end
      end
      7'b1100111: begin
        if (f3 == 3'b000 && imm_i == 12'h000 && rs1 != 5'd0 && rd[4:1] == 4'h0) begin
          c_ok  = 1'b1;
          c_par = {3'b100, rd[0], rs1, 5'd0, 2'b10};
        end
      end
      7'b1100011: begin
        if (f3[2:1] == 2'b00 && rs2 == 5'd0 && rs1_p && ((&bimm[12:8]) || !(|bimm[12:8]))) begin
          c_ok  = 1'b1;
          c_par = {2'b11, f3[0], bimm[8], bimm[4:3], rs1[2:0], bimm[7:6], bimm[2:1], bimm[5], 2'b01};
        end
      end
      7'b1110011: begin
        if (instr_i == 32'h0010_0073) begin
          c_ok  = 1'b1;
          c_par = 16'h9002;
        end
      end
      default: ;
    endcase
  end

  assign is16 = !in32 || c_ok;
  assign p16  = in32 ? c_par : instr_i[15:0];

  logic             state_q, state_d;
  logic [15:0]      held_q, held_d;
  logic [31:0]      word_q, word_d;
  logic             wvalid_q, wvalid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign instr_ready_o = !wvalid_q || word_ready_i;
  assign accept        = instr_valid_i && instr_ready_o;

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    word_d   = word_q;
    wvalid_d = wvalid_q && !word_ready_i;
    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, accept && in32 && c_ok};
    if (accept) begin
      if (state_q == S_EMPTY) begin
        if (is16) begin
          held_d  = p16;
          state_d = S_HALF;
        end else begin
          word_d   = instr_i;
          wvalid_d = 1'b1;
        end
      end else if (is16) begin
        word_d   = {p16, held_q};
        wvalid_d = 1'b1;
        state_d  = S_EMPTY;
      end else begin
        word_d   = {instr_i[15:0], held_q};
        wvalid_d = 1'b1;
        held_d   = instr_i[31:16];
      end
    end else if (flush_i && instr_ready_o && state_q == S_HALF) begin
      // Pad the odd halfword with C.NOP so the word stays executable.
      word_d   = {16'h0001, held_q};
      wvalid_d = 1'b1;
      state_d  = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      held_q   <= 16'h0000;
      word_q   <= 32'h0000_0000;
      wvalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      word_q   <= word_d;
      wvalid_q <= wvalid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = wvalid_q;
  assign idle_o       = (state_q == S_EMPTY) && !wvalid_q;
  assign cmp_count_o  = cnt_q;

endmodule

// File: tb/tb_zeroriscy_compressed_encoder.sv
// tb/tb_zeroriscy_compressed_encoder.sv - directed self-checking bench for zeroriscy_compressed_encoder
module tb_zeroriscy_compressed_encoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        flush;
  logic [31:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        idle;
  logic [2:0]  cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zeroriscy_compressed_encoder #(.CNT_W(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_i(instr),
    .instr_valid_i(instr_valid),
    .instr_ready_o(instr_ready),
    .flush_i(flush),
    .word_o(word),
    .word_valid_o(word_valid),
    .word_ready_i(word_ready),
    .idle_o(idle),
    .cmp_count_o(cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    instr       = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr       = 32'h0;
  endtask

  task automatic flush1();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; instr = 32'h0; instr_valid = 1'b0; flush = 1'b0; word_ready = 1'b1;
    tick();
    tick();
    chk("rst_word", word, 32'h0);
    chk("rst_wvalid", {31'h0, word_valid}, 32'h0);
    chk("rst_ready", {31'h0, instr_ready}, 32'h1);
    chk("rst_idle", {31'h0, idle}, 32'h1);
    chk("rst_cnt", {29'h0, cnt}, 32'h0);
    rst_n = 1'b1;

    send(32'h0014_0413);
    chk("addi1_wvalid", {31'h0, word_valid}, 32'h0);
    chk("addi1_idle", {31'h0, idle}, 32'h0);
    send(32'h0014_0413);
    chk("addi2_wvalid", {31'h0, word_valid}, 32'h1);
    chk("addi2_word", word, 32'h0405_0405);
    chk("addi2_cnt", {29'h0, cnt}, 32'h2);
    tick();
    chk("drain_wvalid", {31'h0, word_valid}, 32'h0);
    chk("drain_idle", {31'h0, idle}, 32'h1);

    send(32'h1234_52B7);
    chk("lui_wvalid", {31'h0, word_valid}, 32'h1);
    chk("lui_word", word, 32'h1234_52B7);
    chk("lui_cnt", {29'h0, cnt}, 32'h2);
    tick();

    send(32'h0014_0413);
    send(32'h1234_52B7);
    chk("mix_word", word, 32'h52B7_0405);
    chk("mix_cnt", {29'h0, cnt}, 32'h3);
    flush1();
    chk("mixflush_wvalid", {31'h0, word_valid}, 32'h1);
    chk("mixflush_word", word, 32'h0001_1234);
    tick();
    chk("mixflush_idle", {31'h0, idle}, 32'h1);

    send(32'h0010_0073);
    flush = 1'b1;
    word_ready = 1'b0;
    tick();
    chk("ebrk_wvalid", {31'h0, word_valid}, 32'h1);
    chk("ebrk_word", word, 32'h0001_9002);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_word", word, 32'h0001_9002);
      chk("stall_ready", {31'h0, instr_ready}, 32'h0);
      chk("stall_wvalid", {31'h0, word_valid}, 32'h1);
    end
    word_ready = 1'b1;
    #1;
    chk("release_ready", {31'h0, instr_ready}, 32'h1);
    tick();
    chk("release_wvalid", {31'h0, word_valid}, 32'h0);
    chk("release_idle", {31'h0, idle}, 32'h1);
    chk("ebrk_cnt", {29'h0, cnt}, 32'h4);
    flush = 1'b0;

    send(32'h0081_2503);
`ifdef ZERORISCY_CENC_STACK_EN
    chk("lwsp_wvalid", {31'h0, word_valid}, 32'h0);
    flush1();
    chk("lwsp_word", word, 32'h0001_4522);
    chk("lwsp_wvalid2", {31'h0, word_valid}, 32'h1);
    chk("lwsp_cnt", {29'h0, cnt}, 32'h5);
`else
    chk("lw_wvalid", {31'h0, word_valid}, 32'h1);
    chk("lw_word", word, 32'h0081_2503);
    flush1();
    chk("lw_flush_wvalid", {31'h0, word_valid}, 32'h0);
    chk("lw_flush_idle", {31'h0, idle}, 32'h1);
    chk("lw_cnt", {29'h0, cnt}, 32'h4);
`endif
    tick();

    send(32'h0014_0413);
    chk("pre_rst_idle", {31'h0, idle}, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_idle", {31'h0, idle}, 32'h1);
    chk("midrst_wvalid", {31'h0, word_valid}, 32'h0);
    chk("midrst_cnt", {29'h0, cnt}, 32'h0);
    send(32'h1234_52B7);
    chk("postrst_word", word, 32'h1234_52B7);
    chk("postrst_wvalid", {31'h0, word_valid}, 32'h1);

    send(32'h00B0_0533);
    send(32'h0094_2223);
    chk("mv_sw_word", word, 32'hC044_852E);
    chk("mv_sw_cnt", {29'h0, cnt}, 32'h2);
    send(32'hFFFF_F06F);
    send(32'h0004_0463);
    chk("j_beqz_word", word, 32'hC401_BFFD);
    chk("j_beqz_cnt", {29'h0, cnt}, 32'h4);
    send(32'h0032_9293);
    send(32'h4094_0433);
    chk("slli_sub_word", word, 32'h8C05_028E);
    chk("slli_sub_cnt", {29'h0, cnt}, 32'h6);
    send(32'h0000_4501);
    send(32'h0204_0413);
    chk("rvc_wide_word", word, 32'h0413_4501);
    chk("rvc_wide_cnt", {29'h0, cnt}, 32'h6);
    flush1();
    chk("rvc_wide_flush", word, 32'h0001_0204);
    send(32'h0014_0413);
    send(32'h0014_0413);
    chk("wrap_word", word, 32'h0405_0405);
    chk("wrap_cnt", {29'h0, cnt}, 32'h0);
    tick();
    chk("final_idle", {31'h0, idle}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
